// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a Wishbone classic refill port.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache #(
  parameter int LINE_NUM   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv,
  input  logic [31:0] s_adr,
  input  logic        s_stb,
  input  logic        s_cyc,
  input  logic        s_we,
  input  logic [3:0]  s_sel,
  output logic [31:0] s_dat_o,
  output logic        s_ack,
  output logic [31:0] m_adr,
  output logic        m_stb,
  output logic        m_cyc,
  output logic        m_we,
  output logic [3:0]  m_sel,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

  state_t              r_state, w_next;
  logic [31:2]         r_req_adr;
  logic [OFF_W-1:0]    r_cnt;
  logic [LINE_NUM-1:0] r_valid;
  logic                r_inv_pend;
  logic [TAG_W-1:0]    r_tag  [LINE_NUM];
  logic [31:0]         r_data [LINE_NUM*LINE_WORDS];

  logic                w_req, w_match, w_hit, w_last, w_fill_done;
  logic [OFF_W-1:0]    w_off;
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [31:0]         w_word;
  logic                w_unused;

  assign w_unused    = ^{s_adr[1:0], s_we, s_sel};
  assign w_req       = s_cyc & s_stb;
  assign w_match     = w_req && (s_adr[31:2] == r_req_adr);
  assign w_off       = r_req_adr[OFF_W+1:2];
  assign w_idx       = r_req_adr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag       = r_req_adr[31:OFF_W+IDX_W+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word      = r_data[{w_idx, w_off}];
  assign w_last      = (r_cnt == OFF_W'(LINE_WORDS - 1));
  assign w_fill_done = (r_state == REFILL) && m_ack && w_last;

  always_comb begin
    w_next  = r_state;
    s_ack   = 1'b0;
    s_dat_o = '0;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_sel   = '0;
    m_adr   = '0;
    case (r_state)
      IDLE: if (w_req) w_next = LOOKUP;
      LOOKUP: begin
        if (w_hit) begin
          w_next = IDLE;
          if (w_match) begin
            s_ack   = 1'b1;
            s_dat_o = w_word;
          end
        end else begin
          w_next = REFILL;
        end
      end
      REFILL: begin
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_sel = '1;
        m_adr = {r_req_adr[31:OFF_W+2], r_cnt, 2'b00};
        if (m_ack && w_last) w_next = RESP;
      end
      RESP: begin
        // Response is dropped if the fetch stage redirected while refilling.
        w_next = IDLE;
        if (w_match) begin
          s_ack   = 1'b1;
          s_dat_o = w_word;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req_adr  <= '0;
      r_cnt      <= '0;
      r_valid    <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) r_req_adr <= s_adr[31:2];
      if (r_state == LOOKUP)                r_cnt <= '0;
      else if (r_state == REFILL && m_ack)  r_cnt <= r_cnt + OFF_W'(1);
      if (r_state == LOOKUP)               r_inv_pend <= 1'b0;
      else if (r_state == REFILL && inv)   r_inv_pend <= 1'b1;
      // An invalidate seen at any point during the refill keeps the new line invalid.
      if (inv)                             r_valid <= '0;
      else if (w_fill_done && !r_inv_pend) r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == REFILL && m_ack) r_data[{w_idx, r_cnt}] <= m_dat_i;
    if (w_fill_done)                r_tag[w_idx] <= w_tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- LINE_NUM, 64, number of direct-mapped lines (power of 2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2).

REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- inv, in, 1, invalidate all lines (fence.i).
- s_adr, in, 32, fetch byte address from the fetch stage.
- s_stb / s_cyc, in, 1, fetch request strobe / cycle.
- s_we, in, 1, write enable; ignored (read-only).
- s_sel, in, 4, byte select; ignored (full word).
- s_dat_o, out, 32, instruction word.
- s_ack, out, 1, fetch acknowledge.
- m_adr, out, 32, refill word address.
- m_stb / m_cyc, out, 1, memory strobe / cycle.
- m_we, out, 1, memory write enable.
- m_sel, out, 4, memory byte select.
- m_dat_i, in, 32, memory read data.
- m_ack, in, 1, memory acknowledge.
- hit_cnt / miss_cnt, out, 32 each, performance counters; present only with ICACHE_PERF_CNT_EN.

Function
REQ-003 Address split SHALL be: offset = s_adr[log2(LINE_WORDS)+1:2]; index = next log2(LINE_NUM) bits; tag = remaining upper bits. s_adr[1:0] SHALL be ignored.
REQ-004 Each line SHALL hold a valid bit, a tag and LINE_WORDS data words. Storage SHALL be register or BRAM with a registered read.
REQ-005 The FSM SHALL have states IDLE, LOOKUP, REFILL and RESP.
REQ-006 In IDLE with s_cyc&s_stb=1, the block SHALL capture s_adr into req_adr and go to LOOKUP.
REQ-007 In LOOKUP on a hit (valid & tag match), the block SHALL drive s_ack=1 with the word in this cycle and return to IDLE. Hit latency is therefore 2 cycles from request.
REQ-008 In LOOKUP on a miss, the block SHALL go to REFILL with word counter = 0.
REQ-009 In REFILL, m_cyc=m_stb=1, m_we=0, m_sel=4'b1111 and m_adr = {line base of req_adr, counter, 2'b00}.
- Each m_ack SHALL write m_dat_i into the line and increment the counter.
- After word LINE_WORDS-1 is acked, the block SHALL set valid, write the tag and go to RESP.
REQ-010 Refill SHALL always start at word 0, with no critical-word-first. m_stb SHALL be held until m_ack (Wishbone classic).
REQ-011 In RESP, s_ack=1 and s_dat_o = the req_adr word for one cycle, then the FSM SHALL go to IDLE.
REQ-012 s_ack SHALL be asserted only if s_cyc&s_stb=1 and s_adr[31:2]==req_adr[31:2] in that cycle. Otherwise the response SHALL be dropped and the FSM SHALL go to IDLE, covering a redirect or flush mid-miss.
REQ-013 A refill in progress SHALL complete even if the upstream request is withdrawn. No partial line SHALL ever be marked valid.
REQ-014 When inv=1, all valid bits SHALL be cleared in the next cycle.
- If inv is asserted during REFILL, the line being filled SHALL NOT be marked valid.
- The pending response SHALL still return refilled data.
REQ-015 When s_we=1, the request SHALL be acked like a read and SHALL not modify contents.
REQ-016 s_ack SHALL never be asserted in two consecutive cycles for a single request.

Reset
REQ-017 On rst:
- FSM = IDLE.
- All valid bits = 0.
- s_ack=0, s_dat_o=0.
- m_cyc=m_stb=m_we=0, m_adr=0, m_sel=0.
- Counters = 0.
REQ-018 rst asserted mid-REFILL SHALL drop m_cyc immediately. After reset the line SHALL be invalid.

Configuration
REQ-019 With ICACHE_PERF_CNT_EN defined:
- hit_cnt SHALL increment on each LOOKUP hit.
- miss_cnt SHALL increment on each LOOKUP miss.
- Both SHALL wrap modulo 2^32.
REQ-020 Without ICACHE_PERF_CNT_EN, the counter ports and logic SHALL be absent. Function SHALL be otherwise identical.

Verification
REQ-021 Cold miss at 0x8000_0010: 4 memory reads SHALL occur at 0x8000_0010..0x8000_001C. s_ack SHALL return mem[0x8000_0010] in RESP. miss_cnt SHALL be 1.
REQ-022 A repeat fetch of 0x8000_0014 after REQ-021 SHALL be acked 2 cycles after the request with no m_cyc. hit_cnt SHALL be 1.
REQ-023 0x8000_0010 then 0x8000_0410 (same index, different tag, LINE_NUM=64) SHALL both miss. Re-fetching 0x8000_0010 SHALL miss again (evicted).
REQ-024 If s_adr changes to 0x8000_0100 during a 0x8000_0020 refill, the first line SHALL finish filling, no ack SHALL be given for 0x8000_0020, and 0x8000_0100 SHALL then be serviced.
REQ-025 Pulsing inv after warm hits SHALL make the next fetch of the same address miss and refill.
REQ-026 With m_ack delayed 3 cycles per word, m_stb and m_adr SHALL stay stable until each ack, and rst mid-refill SHALL force m_cyc=0 in the same cycle.
